bch_syndrome: RTL
=================

# bch_syndrome

Streaming syndrome generator that sits directly upstream of the Berlekamp-Massey (ibm) stage in the BCH decoder. It accepts one received codeword bit per cycle, computes S1..S8 by Horner evaluation over the field selected by the code, and parks the result in a hold bank. It loads the ibm stage with a one-cycle o_clear_and_wen pulse once that stage signals it can take new syndromes. One codeword is accumulated while the previous result waits.

## Interface
- No parameters; field widths are fixed at 10 bits (m < 10 fields zero-padded in upper bits).
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst  input  1  synchronous reset, active-high.
- i_code  input  2  00: GF(2^6), n=63; 01: GF(2^8), n=255; 10: GF(2^10), n=1023; 11 reserved (treated as 00).
- i_in_valid  input  1  i_bit is valid this cycle.
- i_bit  input  1  received bit; first bit of a codeword is the coefficient of x^(n-1).
- o_in_ready  output  1  bit accepted on i_in_valid & o_in_ready.
- i_next_S  input  1  ibm o_next_S; ibm will accept new syndromes from the next cycle.
- o_clear_and_wen  output  1  one-cycle load pulse to ibm i_clear_and_wen.
- o_code  output  2  code of the held syndromes; drives ibm i_code.
- o_S1..o_S8  output  10 each  held syndromes.
- o_err_free  output  1  all eight held syndromes are zero.

## Operation
- Field polynomials: GF(2^6) x^6+x+1; GF(2^8) x^8+x^4+x^3+x^2+1; GF(2^10) x^10+x^3+1.
- Multiply-by-alpha = shift left 1, XOR the polynomial low terms if bit m-1 was set, mask to m bits. Constant alpha^j (j=1..8) = j chained alpha steps.
- Accumulator: eight 10-bit registers acc_j, 10-bit bit counter, latched code reg, flag acc_done.
- On an accepted bit with counter==0, latch i_code. i_code is ignored for the rest of the codeword.
- Each accepted bit: acc_j <= acc_j*alpha^j XOR i_bit, for all j. Counter increments.
- When the bit accepted is bit n-1 of the latched code: counter <= 0 and acc_done <= 1.
- o_in_ready = !acc_done (and 0 during reset).
- Hold bank: S1..S8, code, flag hold_full.
- Transfer: acc_done & (!hold_full | o_clear_and_wen) -> hold <= acc and latched code. Same edge: hold_full <= 1, acc cleared to 0, acc_done <= 0.
- ibm_free flag: reset value 1.
  - Set on an edge where i_next_S = 1.
  - Cleared on an edge where o_clear_and_wen = 1; clear wins if both occur.
- o_clear_and_wen = hold_full & ibm_free (combinational, registered terms only). On that edge hold_full <= 0 unless a transfer refills it.
- o_S*, o_code, o_err_free reflect the hold bank continuously. They are valid and stable during the o_clear_and_wen cycle.
- All eight syndromes are computed for every code; the consumer selects what it uses.

## Timing
- Reset values:
  - o_S1..o_S8 = 0, o_code = 00, o_err_free = 1, o_clear_and_wen = 0, o_in_ready = 0 while i_rst is high.
  - After reset: o_in_ready = 1, hold empty, ibm_free = 1.
- Reset mid-codeword discards the partial accumulator and the hold bank. No pulse is issued.
- Last bit accepted in cycle T:
  - T+1: acc_done = 1, o_in_ready = 0.
  - Edge ending T+1: transfer if allowed.
  - T+2: hold_full = 1, o_in_ready = 1.
  - o_clear_and_wen = 1 in T+2 if ibm_free = 1.
- Throughput: one bubble cycle per codeword when nothing is stalled.
- Backpressure: with hold full and ibm busy, acc_done stays 1 and o_in_ready stays 0. Input is stalled indefinitely without loss.
- i_next_S high in cycle U -> earliest o_clear_and_wen is cycle U+1.
- Simultaneous pulse and transfer on the same edge: the hold bank takes the new syndromes and stays full. The new set is pulsed only after the next i_next_S.
- Gaps in i_in_valid mid-codeword: accumulator and counter hold.

## Test plan
- Reset, code 00, 63 zero bits -> T+2 hold: all S = 0, o_err_free = 1, o_code = 00. One-cycle o_clear_and_wen in T+2.
- Code 00: 62 zeros then one 1 -> all S_j = 0x001. Code 00: 61 zeros, 1, 0 -> S1 = 0x002, S6 = 0x003, S7 = 0x006, S8 = 0x00C.
- Code 10: 1 then 1022 zeros -> S1 = 0x204 (alpha^-1). Code 01: 247 zeros, 1, 7 zeros -> S1 = 0x080, o_err_free = 0.
- Back-to-back codewords with i_next_S held low after the first pulse:
  - Second codeword completes and transfers.
  - Third codeword's last bit leaves o_in_ready = 0.
  - i_next_S pulse -> o_clear_and_wen the next cycle, transfer on the same edge, o_in_ready = 1 the cycle after.
- i_code toggled mid-codeword and random i_in_valid gaps -> syndromes match a software model using the code latched on the first bit.
- i_rst asserted at bit 100 of a code-10 word -> no pulse. Next complete code-00 word produces correct syndromes.

Source files
------------

// File: rtl/bch_syndrome.sv
// bch_syndrome
// Streaming BCH syndrome generator feeding the Berlekamp-Massey (ibm) stage.
// Accepts one received bit per cycle, MSB coefficient (x^(n-1)) first, and
// evaluates S1..S8 by Horner's rule over GF(2^6), GF(2^8) or GF(2^10).
// A finished accumulation is parked in a hold bank, then handed to ibm with a
// one-cycle o_clear_and_wen pulse. The next codeword accumulates meanwhile.
//
// Ports:
//   i_clk, i_rst         clock, synchronous active-high reset
//   i_code[1:0]          00 GF(2^6) n=63, 01 GF(2^8) n=255, 10 GF(2^10) n=1023,
//                        11 treated as 00; sampled on the first bit only
//   i_in_valid, i_bit    received bit stream
//   o_in_ready           bit accepted when i_in_valid & o_in_ready
//   i_next_S             ibm can take new syndromes from the next cycle
//   o_clear_and_wen      one-cycle load pulse to ibm
//   o_code               code of the held syndromes
//   o_S1..o_S8           held syndromes (10 bits, upper bits zero for m < 10)
//   o_err_free           all held syndromes are zero
module bch_syndrome (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_code,
    input  logic       i_in_valid,
    input  logic       i_bit,
    output logic       o_in_ready,
    input  logic       i_next_S,
    output logic       o_clear_and_wen,
    output logic [1:0] o_code,
    output logic [9:0] o_S1,
    output logic [9:0] o_S2,
    output logic [9:0] o_S3,
    output logic [9:0] o_S4,
    output logic [9:0] o_S5,
    output logic [9:0] o_S6,
    output logic [9:0] o_S7,
    output logic [9:0] o_S8,
    output logic       o_err_free
);

    // One multiply-by-alpha step for the selected field.
    function automatic logic [9:0] mul_alpha(input logic [9:0] x, input logic [1:0] code);
        logic [9:0] y;
        y = x << 1;
        case (code)
            2'b01: begin
                if (x[7]) y = y ^ 10'h01D;
                y = y & 10'h0FF;
            end
            2'b10: begin
                // bit 9 falls off the 10-bit shift, no mask needed
                if (x[9]) y = y ^ 10'h009;
            end
            default: begin
                if (x[5]) y = y ^ 10'h003;
                y = y & 10'h03F;
            end
        endcase
        return y;
    endfunction

    // Multiply by alpha^j as j chained alpha steps (j is constant per instance).
    function automatic logic [9:0] mul_pow(input logic [9:0] x, input int j, input logic [1:0] code);
        logic [9:0] y;
        y = x;
        for (int k = 0; k < j; k++) y = mul_alpha(y, code);
        return y;
    endfunction

    function automatic logic [9:0] last_idx(input logic [1:0] code);
        case (code)
            2'b01:   return 10'd254;
            2'b10:   return 10'd1022;
            default: return 10'd62;
        endcase
    endfunction

    logic [7:0][9:0] acc, acc_nxt, hold;
    logic [9:0]      cnt;
    logic [1:0]      code_q, code_use, hold_code;
    logic            acc_done, hold_full, ibm_free;
    logic            take, last, xfer;

    assign o_in_ready      = !acc_done && !i_rst;
    assign o_clear_and_wen = hold_full && ibm_free && !i_rst;
    assign take            = i_in_valid && o_in_ready;
    // A finished accumulation moves into the hold bank whenever the bank is
    // empty or is being unloaded on this very edge.
    assign xfer            = acc_done && (!hold_full || o_clear_and_wen);

    always_comb begin
        // The first bit of a codeword uses the live code; 11 folds to 00.
        code_use = code_q;
        if (cnt == 10'd0) code_use = (i_code == 2'b11) ? 2'b00 : i_code;
        last = (cnt == last_idx(code_use));
        acc_nxt = '0;
        for (int j = 0; j < 8; j++)
            acc_nxt[j] = mul_pow(acc[j], j + 1, code_use) ^ {9'b0, i_bit};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            acc       <= '0;
            cnt       <= '0;
            code_q    <= '0;
            acc_done  <= 1'b0;
            hold      <= '0;
            hold_code <= '0;
            hold_full <= 1'b0;
            ibm_free  <= 1'b1;
        end else begin
            if (xfer) begin
                hold      <= acc;
                hold_code <= code_q;
                acc       <= '0;
                acc_done  <= 1'b0;
            end else if (take) begin
                acc    <= acc_nxt;
                code_q <= code_use;
                if (last) begin
                    cnt      <= '0;
                    acc_done <= 1'b1;
                end else begin
                    cnt <= cnt + 10'd1;
                end
            end

            // A transfer on the unload edge keeps the bank full.
            if (xfer)                 hold_full <= 1'b1;
            else if (o_clear_and_wen) hold_full <= 1'b0;

            if (o_clear_and_wen) ibm_free <= 1'b0;
            else if (i_next_S)   ibm_free <= 1'b1;
        end
    end

    assign o_code     = hold_code;
    assign o_S1       = hold[0];
    assign o_S2       = hold[1];
    assign o_S3       = hold[2];
    assign o_S4       = hold[3];
    assign o_S5       = hold[4];
    assign o_S6       = hold[5];
    assign o_S7       = hold[6];
    assign o_S8       = hold[7];
    assign o_err_free = (hold == '0);

endmodule
